// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : Moore control FSM for the multicycle RV32I core (IF/ID/EX/MEM/WB)
//           with parametrised memory wait states. Optional macro ECALL_HALT_EN
//           turns ECALL into a sticky HALT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_fsm #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [2:0] state_o,
    output logic       is_halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_WB_J = 3'd5,
        S_PC4  = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [6:0] C_OP_R     = 7'b0110011;
    localparam logic [6:0] C_OP_I     = 7'b0010011;
    localparam logic [6:0] C_OP_LD    = 7'b0000011;
    localparam logic [6:0] C_OP_ST    = 7'b0100011;
    localparam logic [6:0] C_OP_BR    = 7'b1100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_JALR  = 7'b1100111;
    localparam logic [6:0] C_OP_ECALL = 7'b1110011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_last;

    assign w_last = (cnt_q == CNT_W'(MEM_LATENCY - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                if (w_last) begin
                    // No IR latch while reset is held, even though IF is "last" at latency 1.
                    IRWrite = ~reset;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                ALUSrcB = 2'b10;
                case (opcode)
                    C_OP_R, C_OP_I, C_OP_LD, C_OP_ST,
                    C_OP_BR, C_OP_JAL, C_OP_JALR: state_d = S_EX;
`ifdef ECALL_HALT_EN
                    C_OP_ECALL:                   state_d = S_HALT;
`else
                    C_OP_ECALL:                   state_d = S_PC4;
`endif
                    default:                      state_d = S_PC4;
                endcase
            end
            S_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    C_OP_R: begin
                        ALUSrcB = 2'b00;
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                    C_OP_I: begin
                        ALUOp   = 2'b10;
                        state_d = S_WB;
                    end
                    C_OP_LD, C_OP_ST: state_d = S_MEM;
                    C_OP_BR: begin
                        ALUSrcB     = 2'b00;
                        ALUOp       = 2'b01;
                        PCWriteCond = 1'b1;
                        PCSource    = 2'b01;
                        state_d     = alu_bcond ? S_IF : S_PC4;
                    end
                    C_OP_JAL: begin
                        ALUSrcA = 1'b0;
                        state_d = S_WB_J;
                    end
                    C_OP_JALR: state_d = S_WB_J;
                    default:   state_d = S_PC4;
                endcase
            end
            S_MEM: begin
                IorD = 1'b1;
                if (opcode == C_OP_LD) begin
                    MemRead = 1'b1;
                    if (w_last) state_d = S_WB;
                end else if (w_last) begin
                    MemWrite = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcB  = 2'b01;
                    state_d  = S_IF;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (opcode == C_OP_LD) ? 2'b01 : 2'b00;
                PCWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                state_d  = S_IF;
            end
            S_WB_J: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                ALUSrcB  = 2'b01;
                PCWrite  = 1'b1;
                PCSource = (opcode == C_OP_JAL) ? 2'b01 : 2'b10;
                state_d  = S_IF;
            end
            S_PC4: begin
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_IF) || (state_q == S_MEM)))
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign state_o = state_q;

`ifdef ECALL_HALT_EN
    assign is_halted = (state_q == S_HALT);
`else
    assign is_halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
// Module  : tb_multicycle_control_fsm
// Brief   : Randomised bench for multicycle_control_fsm at latencies 1, 2 and 3
//           against a per-instruction cycle-schedule reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    localparam logic [6:0] C_OP_R     = 7'b0110011;
    localparam logic [6:0] C_OP_I     = 7'b0010011;
    localparam logic [6:0] C_OP_LD    = 7'b0000011;
    localparam logic [6:0] C_OP_ST    = 7'b0100011;
    localparam logic [6:0] C_OP_BR    = 7'b1100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_JALR  = 7'b1100111;
    localparam logic [6:0] C_OP_ECALL = 7'b1110011;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic [1:0] mtr;
        logic [1:0] pcs;
        logic [1:0] aop;
        logic       asa;
        logic [1:0] asb;
        logic       rw;
        logic [2:0] st;
        logic       h;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic [6:0] opc [3];
    logic       bcond [3];
    ctl_t       obs [3];

    int n_vec;
    int n_err;
    ctl_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic       pcw, pcwc, iord, mr, mw, irw, asa, rw, h;
        logic [1:0] mtr, pcs, aop, asb;
        logic [2:0] st;

        multicycle_control_fsm #(.MEM_LATENCY(k + 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .opcode     (opc[k]),
            .alu_bcond  (bcond[k]),
            .PCWrite    (pcw),
            .PCWriteCond(pcwc),
            .IorD       (iord),
            .MemRead    (mr),
            .MemWrite   (mw),
            .IRWrite    (irw),
            .MemtoReg   (mtr),
            .PCSource   (pcs),
            .ALUOp      (aop),
            .ALUSrcA    (asa),
            .ALUSrcB    (asb),
            .RegWrite   (rw),
            .state_o    (st),
            .is_halted  (h)
        );

        assign obs[k] = {pcw, pcwc, iord, mr, mw, irw, mtr, pcs, aop, asa, asb, rw, st, h};
    end

    task automatic check(input string tag, input ctl_t got, input ctl_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t in_state(input int s);
        ctl_t c = '0;
        c.st = s[2:0];
        return c;
    endfunction

    function automatic ctl_t alu_cyc(input int s, input logic a, input logic [1:0] b, input logic [1:0] op);
        ctl_t c = in_state(s);
        c.asa = a;
        c.asb = b;
        c.aop = op;
        return c;
    endfunction

    // Any cycle that writes PC+4 (sequential PC update).
    function automatic ctl_t pc_plus4(input int s);
        ctl_t c = in_state(s);
        c.pcw = 1'b1;
        c.asb = 2'b01;
        return c;
    endfunction

    function automatic ctl_t reset_vec();
        ctl_t c = in_state(0);
        c.mr = 1'b1;
        return c;
    endfunction

    // Expected per-cycle control schedule of one instruction, fetch to retire.
    task automatic build(input int lat, input logic [6:0] op, input logic bc, output bit halts);
        ctl_t c;
        halts = 1'b0;
        q.delete();
        for (int i = 0; i < lat; i++) begin
            c = in_state(0);
            c.mr  = 1'b1;
            c.irw = (i == lat - 1);
            q.push_back(c);
        end
        q.push_back(alu_cyc(1, 1'b0, 2'b10, 2'b00));
        case (op)
            C_OP_R, C_OP_I: begin
                q.push_back(alu_cyc(2, 1'b1, (op == C_OP_R) ? 2'b00 : 2'b10, 2'b10));
                c = pc_plus4(4);
                c.rw = 1'b1;
                q.push_back(c);
            end
            C_OP_LD, C_OP_ST: begin
                q.push_back(alu_cyc(2, 1'b1, 2'b10, 2'b00));
                for (int i = 0; i < lat; i++) begin
                    c = in_state(3);
                    c.iord = 1'b1;
                    if (op == C_OP_LD) c.mr = 1'b1;
                    else if (i == lat - 1) begin
                        c.mw  = 1'b1;
                        c.pcw = 1'b1;
                        c.asb = 2'b01;
                    end
                    q.push_back(c);
                end
                if (op == C_OP_LD) begin
                    c = pc_plus4(4);
                    c.rw  = 1'b1;
                    c.mtr = 2'b01;
                    q.push_back(c);
                end
            end
            C_OP_BR: begin
                c = alu_cyc(2, 1'b1, 2'b00, 2'b01);
                c.pcwc = 1'b1;
                c.pcs  = 2'b01;
                q.push_back(c);
                if (!bc) q.push_back(pc_plus4(6));
            end
            C_OP_JAL, C_OP_JALR: begin
                q.push_back(alu_cyc(2, op == C_OP_JALR, 2'b10, 2'b00));
                c = pc_plus4(5);
                c.rw  = 1'b1;
                c.mtr = 2'b10;
                c.pcs = (op == C_OP_JAL) ? 2'b01 : 2'b10;
                q.push_back(c);
            end
`ifdef ECALL_HALT_EN
            C_OP_ECALL: begin
                c = in_state(7);
                c.h = 1'b1;
                for (int i = 0; i < 20; i++) q.push_back(c);
                halts = 1'b1;
            end
`endif
            default: q.push_back(pc_plus4(6));
        endcase
    endtask

    // Entered and left on a falling edge; asserts reset for one full cycle.
    task automatic do_reset(input int k);
        reset = 1'b1;
        #1;
        check($sformatf("reset L%0d", k + 1), obs[k], reset_vec());
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_instr(input int k, input logic [6:0] op, input logic bc, input int limit);
        bit halts;
        opc[k]   = op;
        bcond[k] = bc;
        build(k + 1, op, bc, halts);
        for (int i = 0; i < q.size() && i < limit; i++) begin
            #1;
            check($sformatf("L%0d op=%b bc=%0d cyc%0d", k + 1, op, bc, i), obs[k], q[i]);
            @(negedge clk);
        end
        if (halts) do_reset(k);
    endtask

    logic [6:0] dir_ops [9];
    initial begin
        dir_ops = '{C_OP_R, C_OP_I, C_OP_LD, C_OP_ST, C_OP_BR, C_OP_BR,
                    C_OP_JAL, C_OP_JALR, C_OP_ECALL};
    end

    initial begin
        logic [6:0] op;
        logic [31:0] rnd;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opc[k]   = C_OP_R;
            bcond[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("por L%0d", k + 1), obs[k], reset_vec());
        reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            do_reset(k);
            // Abort in EX: fetch+decode, then reset while sitting in EX.
            run_instr(k, C_OP_R, 1'b0, k + 2);
            do_reset(k);
            for (int d = 0; d < 9; d++) run_instr(k, dir_ops[d], (d == 4), 1000);
            run_instr(k, 7'b1111111, 1'b0, 1000);
            for (int n = 0; n < 30; n++) begin
                rnd = $urandom();
                if (rnd[3:0] > 4'd9) op = rnd[10:4];
                else op = dir_ops[rnd[3:0] % 9];
                run_instr(k, op, rnd[31], 1000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Next-generation control unit for the multicycle RV32I core.
- Moore FSM sequences IF/ID/EX/MEM/WB and drives all datapath control strobes from the current state and opcode.
- Adds parametrised memory latency (wait-state counter), JAL/JALR sequencing, widened mux selects, and a debug state output.
- Sits between the instruction register (opcode) and the datapath muxes, register file and unified memory.

Parameters:
- MEM_LATENCY, 1, cycles per memory access (>=1); applies to fetch and to data access.
- CNT_W, $clog2(MEM_LATENCY+1), wait-counter width (derived; not overridden).

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  7  IR[6:0]
- alu_bcond  input  1  branch condition from ALU, valid in EX of a branch
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  datapath writes PC when PCWriteCond & alu_bcond
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe (one cycle per store)
- IRWrite  output  1  latch instruction register
- MemtoReg  output  2  RF write data: 00 ALUOut, 01 MDR, 10 ALU result
- PCSource  output  2  PC input: 00 ALU result, 01 ALUOut, 10 ALUOut with bit0 cleared
- ALUOp  output  2  00 add, 01 branch compare, 10 funct-decoded
- ALUSrcA  output  1  0 = PC, 1 = rs1
- ALUSrcB  output  2  00 rs2, 01 constant 4, 10 immediate
- RegWrite  output  1  register file write
- state_o  output  3  current state (debug)
- is_halted  output  1  sticky halt flag

Behaviour:
- Encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, WB_J=5, PC4=6, HALT=7.
- Reset (async): state=IF, wait counter=0, is_halted=0. Outputs therefore take IF values: MemRead=1, IorD=0; all other strobes 0; selects 00.
- All outputs are combinational from state, counter and opcode. No output depends on alu_bcond except the next-state choice.
- Unlisted outputs are 0 / 00 in every state.
- Wait counter:
  - Increments each cycle in IF and MEM.
  - A cycle is "last" when cnt==MEM_LATENCY-1.
  - Clears to 0 on every state transition.
  - With MEM_LATENCY=1, every IF/MEM cycle is last.
- Opcode classes: R=0110011, I=0010011, LD=0000011, ST=0100011, BR=1100011, JAL=1101111, JALR=1100111, ECALL=1110011. All others are illegal.
- IF:
  - MemRead=1, IorD=0.
  - On the last cycle: IRWrite=1, next=ID.
  - Otherwise stay in IF.
- ID:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00, so ALUOut<=PC+imm.
  - ECALL or illegal opcode -> PC4. All other classes -> EX.
- EX:
  - R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB.
  - I: ALUSrcA=1, ALUSrcB=10, ALUOp=10 -> WB.
  - LD/ST: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM.
  - BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next = IF if alu_bcond=1, else PC4.
  - JAL: ALUSrcA=0, ALUSrcB=10, ALUOp=00 -> WB_J.
  - JALR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_J.
- MEM:
  - IorD=1 throughout.
  - LD: MemRead=1 every cycle. On the last cycle -> WB.
  - ST: on the last cycle only, MemWrite=1 and PCWrite=1, with ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 -> IF.
- WB:
  - RegWrite=1; MemtoReg=01 for LD, 00 otherwise.
  - PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 -> IF.
- WB_J:
  - RegWrite=1, MemtoReg=10, ALUSrcA=0, ALUSrcB=01, ALUOp=00 (link = PC+4).
  - PCWrite=1; PCSource=01 for JAL, 10 for JALR -> IF.
- PC4: PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 -> IF.
- HALT: all strobes 0; state held until reset.
- opcode must be stable from ID until return to IF. The FSM does not re-latch it.
- Reset asserted mid-instruction aborts immediately. No partial-write guarantee beyond strobes already issued.

Optional Feature:
- Macro ECALL_HALT_EN.
- Defined: ECALL in ID -> HALT; is_halted=1 from the HALT cycle until reset.
- Undefined: ECALL behaves as a NOP (ID -> PC4 -> IF); HALT is unreachable; is_halted is tied 0.

Test Plan:
- Reset pulse mid-EX, MEM_LATENCY=1 -> state_o=0 immediately after assertion; MemRead=1, IRWrite=0, is_halted=0.
- R-type 0110011, MEM_LATENCY=1 -> states 0,1,2,4,0 (4 cycles); RegWrite=1 and PCWrite=1 only in WB; MemtoReg=00.
- LD 0000011, MEM_LATENCY=3 -> IF 3 cycles with IRWrite only on the 3rd; MEM 3 cycles with IorD=1; WB with MemtoReg=01; total 9 cycles.
- ST 0100011, MEM_LATENCY=2 -> MemWrite=1 exactly once, in the 2nd MEM cycle, coincident with PCWrite=1; no WB state.
- BR 1100011 with alu_bcond=1 -> EX(PCWriteCond=1, PCSource=01) -> IF. With alu_bcond=0 -> EX -> PC4 (PCWrite=1, PCSource=00) -> IF.
- JALR 1100111 -> WB_J with RegWrite=1, MemtoReg=10, PCSource=10. ECALL 1110011 with ECALL_HALT_EN -> state_o=7 and is_halted=1 held 20 cycles; without the macro -> returns to IF via PC4.
